// File: rtl/ibex_ex_sequencer_if.sv
// Shared types and the ID/EX-to-datapath handshake bundle for ibex_ex_sequencer.
// master = ID stage / execute datapath side, slave = the sequencer.
package ibex_pkg;

    typedef enum integer {
        RV32MNone        = 0,
        RV32MSlow        = 1,
        RV32MFast        = 2,
        RV32MSingleCycle = 3
    } rv32m_e;

    localparam int unsigned ImdW = 34;
    localparam int unsigned ImdN = 2;

    typedef logic [ImdW-1:0] imd_t;

endpackage

interface ibex_ex_sequencer_if #(
    parameter int unsigned CntW = 6
);
    logic                                 instr_valid_i;
    logic                                 mult_sel_i;
    logic                                 div_sel_i;
    logic                                 kill_i;
    logic                                 ex_valid_i;
    logic                                 wb_ready_i;
    logic [ibex_pkg::ImdN-1:0]            imd_we_i;
    ibex_pkg::imd_t [ibex_pkg::ImdN-1:0]  imd_d_i;
    ibex_pkg::imd_t [ibex_pkg::ImdN-1:0]  imd_val_q_o;
    logic                                 instr_first_cycle_o;
    logic                                 mult_en_o;
    logic                                 div_en_o;
    logic                                 multdiv_ready_id_o;
    logic                                 instr_done_o;
    logic                                 busy_o;
    logic [CntW-1:0]                      cycle_cnt_o;

    modport master (
        output instr_valid_i, mult_sel_i, div_sel_i, kill_i, ex_valid_i, wb_ready_i,
               imd_we_i, imd_d_i,
        input  imd_val_q_o, instr_first_cycle_o, mult_en_o, div_en_o,
               multdiv_ready_id_o, instr_done_o, busy_o, cycle_cnt_o
    );

    modport slave (
        input  instr_valid_i, mult_sel_i, div_sel_i, kill_i, ex_valid_i, wb_ready_i,
               imd_we_i, imd_d_i,
        output imd_val_q_o, instr_first_cycle_o, mult_en_o, div_en_o,
               multdiv_ready_id_o, instr_done_o, busy_o, cycle_cnt_o
    );

endinterface

// File: rtl/ibex_ex_sequencer.sv
// Execute-stage sequencer: starts/finishes execute instructions, gates mult/div,
// owns the intermediate-value registers and holds results across writeback stalls.
module ibex_ex_sequencer #(
    parameter ibex_pkg::rv32m_e RV32M = ibex_pkg::RV32MFast,
    parameter int unsigned      CntW  = 6
) (
    input logic                clk_i,
    input logic                rst_ni,
    ibex_ex_sequencer_if.slave bus
);

    localparam int unsigned     ImdN     = ibex_pkg::ImdN;
    localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};
    localparam bit              MulDivEn = (RV32M != ibex_pkg::RV32MNone);

    typedef enum logic [1:0] {
        Idle = 2'd0,
        Busy = 2'd1,
        Hold = 2'd2
    } state_e;

    state_e                              state_q, state_d;
    logic [CntW-1:0]                     cnt_q;
    ibex_pkg::imd_t [ImdN-1:0]           imd_q;

    logic go;
    logic in_hold;
    logic abort;
    logic imd_en;
    logic done_c;
    logic first_cycle_c;

    // Loss of instr_valid_i mid-instruction is an abort, same as an explicit kill.
    assign go      = bus.instr_valid_i & ~bus.kill_i;
    assign in_hold = (state_q == Hold);
    assign abort   = bus.kill_i | (~bus.instr_valid_i & (state_q != Idle));
    assign imd_en  = go & ~in_hold;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the done / first-cycle strobes.
    always_comb begin
        state_d       = state_q;
        done_c        = 1'b0;
        first_cycle_c = 1'b0;

        case (state_q)
            Idle: begin
                first_cycle_c = bus.instr_valid_i;
                if (go) begin
                    if (bus.ex_valid_i) begin
                        if (bus.wb_ready_i) begin
                            done_c = 1'b1;
                        end else begin
                            state_d = Hold;
                        end
                    end else begin
                        state_d = Busy;
                    end
                end
            end
            Busy: begin
                if (go && bus.ex_valid_i) begin
                    if (bus.wb_ready_i) begin
                        done_c  = 1'b1;
                        state_d = Idle;
                    end else begin
                        state_d = Hold;
                    end
                end
            end
            Hold: begin
                if (go && bus.wb_ready_i) begin
                    done_c  = 1'b1;
                    state_d = Idle;
                end
            end
            default: begin
                state_d = Idle;
            end
        endcase

        // Kill beats completion in the same cycle.
        if (abort) begin
            state_d = Idle;
            done_c  = 1'b0;
        end
    end

    // Saturating execute-cycle counter; frozen while holding or idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (abort) begin
            cnt_q <= '0;
        end else if (go) begin
            if (state_q == Idle) begin
                cnt_q <= CntW'(1);
            end else if ((state_q == Busy) && (cnt_q != CntMax)) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    // Intermediate values: independent per-register writes, wiped on abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            imd_q <= '0;
        end else if (abort) begin
            imd_q <= '0;
        end else begin
            for (int k = 0; k < int'(ImdN); k++) begin
                if (imd_en && bus.imd_we_i[k]) begin
                    imd_q[k] <= bus.imd_d_i[k];
                end
            end
        end
    end

    assign bus.imd_val_q_o         = imd_q;
    assign bus.cycle_cnt_o         = cnt_q;
    assign bus.instr_first_cycle_o = first_cycle_c;
    assign bus.instr_done_o        = done_c;
    assign bus.busy_o              = (state_q != Idle);
    assign bus.multdiv_ready_id_o  = ~in_hold | bus.wb_ready_i;
    assign bus.mult_en_o           = MulDivEn & bus.mult_sel_i & go & ~in_hold;
    assign bus.div_en_o            = MulDivEn & bus.div_sel_i & go & ~in_hold;

endmodule
